// File: rtl/program_loader_pkg.sv
// Shared constants and types for the program loader.
// The program-counter width is shared with instruction fetch.
package program_loader_pkg;

  localparam int PC_BITS   = 9;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_ACCEPT = 2'd1;
  localparam logic [1:0] STATE_WRITE  = 2'd2;
  localparam logic [1:0] STATE_DONE   = 2'd3;

  localparam logic LANE_HIGH = 1'b1;
  localparam logic LANE_LOW  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_ACCEPT = STATE_ACCEPT,
    ST_WRITE  = STATE_WRITE,
    ST_DONE   = STATE_DONE
  } state_e;

  // Even byte addresses land in the high lane, odd ones in the low lane.
  function automatic logic lane_of(input logic addr_lsb);
    return addr_lsb ? LANE_LOW : LANE_HIGH;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, program RAM write port and status of the program loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                 start;
  logic [PC_BITS-1:0]   startAddress;
  logic [PC_BITS:0]     length;
  logic                 byteValid;
  logic [7:0]           byteData;
  logic                 byteReady;
  logic [ADDR_BITS-1:0] programAddress;
  logic [DATA_BITS-1:0] programDataIn;
  logic                 programWriteEnable;
  logic [1:0]           programWriteMask;
  logic                 busy;
  logic                 finished;
  logic [PC_BITS-1:0]   nextByteAddress;

  modport slave (
    input  start, startAddress, length, byteValid, byteData,
    output byteReady, programAddress, programDataIn, programWriteEnable,
           programWriteMask, busy, finished, nextByteAddress
  );

  modport master (
    output start, startAddress, length, byteValid, byteData,
    input  byteReady, programAddress, programDataIn, programWriteEnable,
           programWriteMask, busy, finished, nextByteAddress
  );

endinterface

// File: rtl/program_loader.sv
// Packs an incoming byte stream into 16-bit program RAM words with per-byte
// write masks, so partial words at either end never disturb neighbouring bytes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int addrBits = ADDR_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  state_e                state_q, state_d;
  logic [PC_BITS-1:0]    byte_addr_q, byte_addr_d;
  logic [PC_BITS:0]      remaining_q, remaining_d;
  logic [dataBits-1:0]   word_q, word_d;
  logic [1:0]            mask_q, mask_d;
  logic [addrBits-1:0]   word_addr_q, word_addr_d;
  logic                  lane_s;

  // State and data-path registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      byte_addr_q <= 9'd0;
      remaining_q <= 10'd0;
      word_q      <= 16'd0;
      mask_q      <= 2'b00;
      word_addr_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_addr_q <= byte_addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      word_addr_q <= word_addr_d;
    end
  end

  assign lane_s = lane_of(byte_addr_q[0]);

  // Next-state and data-path update.
  always_comb begin
    state_d     = state_q;
    byte_addr_d = byte_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    mask_d      = mask_q;
    word_addr_d = word_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          byte_addr_d = bus.startAddress;
          remaining_d = bus.length;
          mask_d      = 2'b00;
          if (bus.length == 10'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_ACCEPT: begin
        if (bus.byteValid) begin
          if (lane_s == LANE_HIGH) begin
            word_d[15:8] = bus.byteData;
          end else begin
            word_d[7:0] = bus.byteData;
          end
          mask_d[lane_s] = 1'b1;
          word_addr_d    = byte_addr_q[8:1];
          byte_addr_d    = byte_addr_q + 9'd1;
          remaining_d    = remaining_q - 10'd1;
          // Flush on a completed word or on the last byte of the load.
          if (byte_addr_q[0] || (remaining_q == 10'd1)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end

      ST_WRITE: begin
        mask_d = 2'b00;
        if (remaining_q == 10'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    bus.byteReady          = 1'b0;
    bus.programWriteEnable = 1'b0;
    bus.programWriteMask   = 2'b00;
    bus.busy               = 1'b0;
    bus.finished           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.busy = 1'b0;
      end
      ST_ACCEPT: begin
        bus.byteReady = 1'b1;
        bus.busy      = 1'b1;
      end
      ST_WRITE: begin
        bus.programWriteEnable = 1'b1;
        bus.programWriteMask   = mask_q;
        bus.busy               = 1'b1;
      end
      ST_DONE: begin
        bus.finished = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.programAddress  = word_addr_q;
  assign bus.programDataIn   = word_q;
  assign bus.nextByteAddress = byte_addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader: aligned, odd, zero-length,
// wrap-around and backpressured loads, plus reset in the middle of a load.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]       sa;
    logic [9:0]       len;
    logic [3:0][7:0]  b;
    int               nw;
    logic [1:0][7:0]  wa;
    logic [1:0][15:0] wd;
    logic [1:0][1:0]  wm;
    logic [1:0][7:0]  wc;
    int               total;
    logic [8:0]       nxt;
    bit               stall;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] sa, input logic [9:0] len,
                              input logic [31:0] bytes, input int nw,
                              input logic [7:0] a0, input logic [15:0] d0, input logic [1:0] m0,
                              input logic [7:0] c0,
                              input logic [7:0] a1, input logic [15:0] d1, input logic [1:0] m1,
                              input logic [7:0] c1,
                              input int total, input logic [8:0] nxt, input bit stall);
    vec_t v;
    v.sa = sa; v.len = len;
    v.b[0] = bytes[31:24]; v.b[1] = bytes[23:16]; v.b[2] = bytes[15:8]; v.b[3] = bytes[7:0];
    v.nw = nw;
    v.wa[0] = a0; v.wd[0] = d0; v.wm[0] = m0; v.wc[0] = c0;
    v.wa[1] = a1; v.wd[1] = d1; v.wm[1] = m1; v.wc[1] = c1;
    v.total = total; v.nxt = nxt; v.stall = stall;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]  got_a[4];
    logic [15:0] got_d[4];
    logic [1:0]  got_m[4];
    int          got_c[4];
    int          nw = 0, idx = 0, gap = 0, cyc = 0, rdy = 0;
    bit          done = 1'b0, mid_done = 1'b0;
    logic [15:0] lm;

    @(negedge clk);
    bus.startAddress = v.sa;
    bus.length       = v.len;
    bus.start        = 1'b1;
    bus.byteValid    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!done && cyc < 300) begin
      cyc++;
      if (bus.programWriteEnable) begin
        if (nw < 4) begin
          got_a[nw] = bus.programAddress;
          got_d[nw] = bus.programDataIn;
          got_m[nw] = bus.programWriteMask;
          got_c[nw] = cyc;
        end
        nw++;
      end
      if (bus.byteReady) rdy++;
      if (bus.finished) begin
        done = 1'b1;
      end else begin
        bus.start = 1'b0;
        // A start while busy must be ignored; use values that would corrupt the load.
        if (v.stall && !mid_done && idx == 2 && bus.busy) begin
          bus.start        = 1'b1;
          bus.startAddress = 9'h0AA;
          bus.length       = 10'd1;
          mid_done         = 1'b1;
        end
        if (gap > 0) begin
          bus.byteValid = 1'b0;
          gap--;
        end else if (idx < int'(v.len)) begin
          bus.byteValid = 1'b1;
          bus.byteData  = v.b[idx];
          if (bus.byteReady) begin
            idx++;
            gap = v.stall ? int'($urandom_range(0, 5)) : 0;
          end
        end else begin
          bus.byteValid = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.byteValid = 1'b0;
    bus.start     = 1'b0;

    check({tag, " finished"}, {31'd0, done}, 32'd1);
    check({tag, " bytes_taken"}, idx, int'(v.len));
    check({tag, " write_count"}, nw, v.nw);
    for (int i = 0; i < v.nw && i < nw; i++) begin
      lm = {{8{v.wm[i][1]}}, {8{v.wm[i][0]}}};
      check($sformatf("%s w%0d_addr", tag, i), {24'd0, got_a[i]}, {24'd0, v.wa[i]});
      check($sformatf("%s w%0d_mask", tag, i), {30'd0, got_m[i]}, {30'd0, v.wm[i]});
      check($sformatf("%s w%0d_data", tag, i), {16'd0, got_d[i] & lm}, {16'd0, v.wd[i] & lm});
      if (!v.stall) check($sformatf("%s w%0d_cycle", tag, i), got_c[i], int'(v.wc[i]));
    end
    if (!v.stall) begin
      check({tag, " total_cycles"}, cyc, v.total);
      check({tag, " ready_cycles"}, rdy, int'(v.len));
    end
    check({tag, " next_addr"}, {23'd0, bus.nextByteAddress}, {23'd0, v.nxt});
    check({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int wr_seen;

    vecs[0] = mk(9'h010, 10'd4, 32'h11223344, 2, 8'h08, 16'h1122, 2'b11, 8'd3,
                 8'h09, 16'h3344, 2'b11, 8'd6, 7, 9'h014, 1'b0);
    vecs[1] = mk(9'h003, 10'd2, 32'hAABB0000, 2, 8'h01, 16'h00AA, 2'b01, 8'd2,
                 8'h02, 16'hBB00, 2'b10, 8'd4, 5, 9'h005, 1'b0);
    vecs[2] = mk(9'h055, 10'd0, 32'h00000000, 0, 8'h00, 16'h0000, 2'b00, 8'd0,
                 8'h00, 16'h0000, 2'b00, 8'd0, 1, 9'h055, 1'b0);
    vecs[3] = mk(9'h1FF, 10'd2, 32'h5AA50000, 2, 8'hFF, 16'h005A, 2'b01, 8'd2,
                 8'h00, 16'hA500, 2'b10, 8'd4, 5, 9'h001, 1'b0);
    vecs[4] = mk(9'h100, 10'd3, 32'h01020300, 2, 8'h80, 16'h0102, 2'b11, 8'd3,
                 8'h81, 16'h0300, 2'b10, 8'd5, 6, 9'h103, 1'b0);
    vecs[5] = mk(9'h010, 10'd4, 32'h11223344, 2, 8'h08, 16'h1122, 2'b11, 8'd0,
                 8'h09, 16'h3344, 2'b11, 8'd0, 0, 9'h014, 1'b1);

    bus.start = 1'b0; bus.startAddress = 9'd0; bus.length = 10'd0;
    bus.byteValid = 1'b0; bus.byteData = 8'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst byteReady", {31'd0, bus.byteReady}, 32'd0);
    check("rst we", {31'd0, bus.programWriteEnable}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst finished", {31'd0, bus.finished}, 32'd0);
    check("rst mask", {30'd0, bus.programWriteMask}, 32'd0);
    check("rst next_addr", {23'd0, bus.nextByteAddress}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset after one byte of a length-4 load: the half word is dropped.
    @(negedge clk);
    bus.startAddress = 9'h020; bus.length = 10'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.byteValid = 1'b1; bus.byteData = 8'h77;
    @(negedge clk);
    bus.byteValid = 1'b0;
    check("mid busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst finished", {31'd0, bus.finished}, 32'd0);
    check("mid_rst byteReady", {31'd0, bus.byteReady}, 32'd0);
    check("mid_rst next_addr", {23'd0, bus.nextByteAddress}, 32'd0);
    wr_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.programWriteEnable || bus.busy) wr_seen++;
      @(negedge clk);
    end
    check("mid_rst no_write", wr_seen, 0);
    run_vec(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of instruction fetch. Accepts a byte stream over a valid/ready handshake and packs the bytes into 16-bit program-memory words at a 9-bit byte program counter.
- Even byte address maps to word bits [15:8]; odd byte address maps to bits [7:0]. Word address is byteAddr[8:1].
- Drives the program RAM write port with a per-byte write mask, so odd start addresses and odd lengths never corrupt neighbouring bytes.
- Sits between the host/boot byte source and program RAM. Runs before the core is released from load.

Parameters:
- addrBits, 8, program RAM word-address width; must equal 8 for the 9-bit byte counter.
- dataBits, 16, program RAM word width; must be 16 (two instruction bytes per word).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE.
- startAddress  in  9  byte address of the first byte.
- length  in  10  byte count, 0..512.
- byteValid  in  1  source has a byte on byteData.
- byteData  in  8  instruction byte.
- byteReady  out  1  loader accepts byteData this cycle.
- programAddress  out  addrBits  RAM word address.
- programDataIn  out  dataBits  RAM write data.
- programWriteEnable  out  1  one-cycle write strobe.
- programWriteMask  out  2  bit1 = write [15:8], bit0 = write [7:0].
- busy  out  1  high in ACCEPT or WRITE.
- finished  out  1  level, high in DONE until the next start.
- nextByteAddress  out  9  byte address of the next byte to be accepted.

Behaviour:
- Registers:
  - rState (IDLE, ACCEPT, WRITE, DONE)
  - rByteAddr[8:0]
  - rRemaining[9:0]
  - rWord[15:0]
  - rMask[1:0]
  - rWordAddr[7:0]
- Reset (reset==0 at posedge):
  - rState=IDLE, rMask=0, rRemaining=0, rByteAddr=0, rWord=0.
  - Outputs: byteReady=0, programWriteEnable=0, busy=0, finished=0, programWriteMask=0.
  - Reset mid-operation abandons the load and issues no further writes. A partially filled word is dropped.
- IDLE/DONE:
  - On start, load rByteAddr=startAddress, rRemaining=length, rMask=0.
  - Go to DONE if length==0, otherwise go to ACCEPT. finished drops in the cycle after start.
- ACCEPT:
  - byteReady=1.
  - A transfer occurs when byteValid&&byteReady. On transfer:
    - If rByteAddr[0]==0: rWord[15:8]=byteData, rMask[1]=1.
    - Otherwise: rWord[7:0]=byteData, rMask[0]=1.
    - rWordAddr=rByteAddr[8:1]; rByteAddr=rByteAddr+1 (9-bit wrap, 0x1FF -> 0x000); rRemaining=rRemaining-1.
    - Go to WRITE if rByteAddr[0]==1 or rRemaining==1; otherwise stay in ACCEPT.
  - No transfer: hold all state. Stall length is unlimited.
- WRITE (exactly one cycle):
  - byteReady=0, programWriteEnable=1.
  - Drive programAddress=rWordAddr, programDataIn=rWord, programWriteMask=rMask.
  - Unmasked byte lanes of programDataIn are don't-care; the bench checks only masked lanes.
  - Next: clear rMask. Go to DONE if rRemaining==0, otherwise to ACCEPT.
- Outside WRITE, programWriteEnable=0 and programWriteMask=0. programAddress is driven from rWordAddr at all times.
- start is ignored while busy.
- Throughput: 2 bytes per 3 cycles with no source stalls. Latency from the last accepted byte to its write strobe is 1 cycle. finished rises the cycle after the final write.
- nextByteAddress is rByteAddr. Its value after DONE equals startAddress+length mod 512.

Decomposition:
- Shared package holds:
  - state localparams: STATE_IDLE=0, STATE_ACCEPT=1, STATE_WRITE=2, STATE_DONE=3
  - byte-lane constants: LANE_HIGH=1, LANE_LOW=0
  - PC_BITS=9, the program-counter width shared with fetch
- No sub-module; the block is one controller plus data-path registers.

Test Plan:
- Even aligned load: start with startAddress=0x010, length=4; bytes 11,22,33,44 with byteValid held high.
  -> Write addr 0x08, data 0x1122, mask 11; 3 cycles later write addr 0x09, data 0x3344, mask 11.
  -> Then finished=1 and nextByteAddress=0x014.
- Odd start and odd end: startAddress=0x003, length=2, bytes AA,BB.
  -> Write addr 0x01, low lane AA, mask 01.
  -> Write addr 0x02, high lane BB, mask 10.
- Zero length: start with length=0.
  -> finished=1 the next cycle; programWriteEnable never asserts; byteReady stays 0.
- Wrap-around: startAddress=0x1FF, length=2, bytes 5A,A5.
  -> Write addr 0xFF, mask 01, low 5A.
  -> Write addr 0x00, mask 10, high A5.
  -> nextByteAddress=0x001.
- Backpressure: repeat scenario 1 with byteValid low for 0–5 random cycles between bytes, plus a start pulse mid-load.
  -> Identical write sequence; the extra start is ignored.
- Reset mid-operation: assert reset after 1 byte of a length-4 load.
  -> Next cycle state IDLE; no write issued; a subsequent start begins cleanly.
